// File: rtl/fifo_step_sequencer_if.sv
// FIFO read-side bundle between the motion-record FIFO and its consumer.
// Carries the empty flag, the read data (valid the cycle after a pop) and the pop strobe.
// The consumer drives the pop strobe and the FIFO side drives the flag and data.
interface fifo_step_sequencer_if #(
  parameter int WORD_SIZE = 8
);
  logic                 fifo_empty;
  logic [WORD_SIZE-1:0] fifo_data_out;
  logic                 fifo_read_en;

  modport master (input fifo_empty, input fifo_data_out, output fifo_read_en);
  modport slave  (output fifo_empty, output fifo_data_out, input fifo_read_en);
endinterface

// File: rtl/fifo_step_sequencer.sv
// Pops 4-byte motion records from the FIFO and plays them out as step/dir pulse trains.
// Latency: 2 cycles per byte fetched, DIR_SETUP cycles of dir setup, then 2*count*H*PRESCALE cycles.
// Backpressure: stalls with busy held while the FIFO is empty mid-record; never pops while empty.
module fifo_step_sequencer #(
  parameter int WORD_SIZE    = 8,
  parameter int RECORD_WORDS = 4,
  parameter int PRESCALE     = 4,
  parameter int DIR_SETUP    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  fifo_step_sequencer_if.master        fifo,
  output logic [3:0]                   step,
  output logic [3:0]                   dir,
  output logic                         busy,
  output logic                         record_done,
  output logic [15:0]                  records_completed
);

  // Wide enough for 255 ticks of PRESCALE cycles with a spare bit.
  localparam int TW = 9 + $clog2(PRESCALE);
  localparam logic [1:0] LAST_IDX = 2'(RECORD_WORDS - 1);

  typedef enum logic [2:0] {IDLE, POP, CAPTURE, SETUP, HIGH, LOW, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 read_en;
  logic [1:0]           idx;
  logic [WORD_SIZE-1:0] rec0;
  logic [WORD_SIZE-1:0] rec1;
  logic [WORD_SIZE-1:0] rec2;
  logic [WORD_SIZE-1:0] rec3;
  logic [WORD_SIZE-1:0] half_ticks;
  logic [15:0]          remaining;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        period;
  logic                 timer_zero;

  // A half-period of zero ticks behaves as one tick.
  assign half_ticks = (rec3 == '0) ? WORD_SIZE'(1) : rec3;
  assign period     = TW'(half_ticks) * TW'(PRESCALE);
  assign timer_zero = (timer == '0);
  assign fifo.fifo_read_en = read_en;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus all outputs derived from the current state.
  always_comb begin
    state_nxt   = state;
    read_en     = 1'b0;
    step        = 4'h0;
    busy        = 1'b0;
    record_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo.fifo_empty) begin
          read_en   = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      POP: begin
        busy = 1'b1;
        if (!fifo.fifo_empty) begin
          read_en   = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        busy      = 1'b1;
        state_nxt = (idx == LAST_IDX) ? SETUP : POP;
      end
      SETUP: begin
        busy = 1'b1;
        if (timer_zero) state_nxt = (remaining == 16'd0) ? DONE : HIGH;
      end
      HIGH: begin
        busy = 1'b1;
        step = rec0[3:0];
        if (timer_zero) state_nxt = LOW;
      end
      LOW: begin
        busy = 1'b1;
        if (timer_zero) state_nxt = (remaining == 16'd1) ? DONE : HIGH;
      end
      DONE: begin
        record_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The pop strobe is the only output not taken from registered state.
    if (reset) read_en = 1'b0;
  end

  // Record capture, dir latch, phase timer, remaining-step and completion counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx               <= 2'd0;
      rec0              <= '0;
      rec1              <= '0;
      rec2              <= '0;
      rec3              <= '0;
      remaining         <= 16'd0;
      timer             <= '0;
      dir               <= 4'h0;
      records_completed <= 16'd0;
    end else begin
      case (state)
        IDLE: idx <= 2'd0;
        CAPTURE: begin
          case (idx)
            2'd0:    rec0 <= fifo.fifo_data_out;
            2'd1:    rec1 <= fifo.fifo_data_out;
            2'd2:    rec2 <= fifo.fifo_data_out;
            default: rec3 <= fifo.fifo_data_out;
          endcase
          idx <= idx + 2'd1;
          if (idx == LAST_IDX) begin
            dir       <= rec0[7:4];
            remaining <= {rec2, rec1};
            timer     <= TW'(DIR_SETUP - 1);
          end
        end
        SETUP, HIGH: begin
          if (timer_zero) timer <= period - TW'(1);
          else            timer <= timer - TW'(1);
        end
        LOW: begin
          if (timer_zero) begin
            timer     <= period - TW'(1);
            remaining <= remaining - 16'd1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: ;
      endcase
      // Counted on entry to DONE so the new total is visible alongside record_done.
      if (state_nxt == DONE) records_completed <= records_completed + 16'd1;
    end
  end

endmodule
